// File: rtl/if_id_buf.sv
// ---------------------------------------------------------------------------
// if_id_buf
//
// Instruction buffer between the fetch (IF) and decode (ID) stages. Each
// fetched instruction is captured together with its PC, static branch
// prediction bit and fetch exception flags, and is presented to ID through a
// valid/ready handshake. A flush discards every held entry.
//
// Build option:
//   IF_ID_SKID_EN  defined   -> two-entry skid queue. if_ready_o comes from
//                               registered state only.
//   IF_ID_SKID_EN  undefined -> single-entry pipeline register. if_ready_o
//                               has a combinational path from id_ready_i.
//
// Parameters:
//   PC_WIDTH     width of the PC fields
//   INSTR_WIDTH  width of the instruction fields
//   NOP_INSTR    value driven on id_instr_o while the buffer is empty
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   if_valid_i          IF offers an entry this cycle
//   if_ready_o          the buffer accepts an entry this cycle
//   if_pc_i, if_instr_i PC and instruction of the offered entry
//   if_prdt_taken_i     static prediction of the offered entry
//   if_pc_misalign_i    fetch-address-misaligned flag of the offered entry
//   if_bus_err_i        fetch bus-error flag of the offered entry
//   flush_i             discard all held and incoming entries
//   id_valid_o          the head entry is valid
//   id_ready_i          ID consumes the head entry this cycle
//   id_pc_o, id_instr_o, id_prdt_taken_o, id_pc_misalign_o, id_bus_err_o
//                       head entry fields (NOP / zero when empty)
//   count_o             number of occupied entries
// ---------------------------------------------------------------------------
module if_id_buf #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid_i,
    output logic                   if_ready_o,
    input  logic [PC_WIDTH-1:0]    if_pc_i,
    input  logic [INSTR_WIDTH-1:0] if_instr_i,
    input  logic                   if_prdt_taken_i,
    input  logic                   if_pc_misalign_i,
    input  logic                   if_bus_err_i,
    input  logic                   flush_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [PC_WIDTH-1:0]    id_pc_o,
    output logic [INSTR_WIDTH-1:0] id_instr_o,
    output logic                   id_prdt_taken_o,
    output logic                   id_pc_misalign_o,
    output logic                   id_bus_err_o,
    output logic [1:0]             count_o
);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   prdt_taken;
        logic                   pc_misalign;
        logic                   bus_err;
    } entry_t;

    logic [1:0] count_q, count_d;
    entry_t     e0_q, e0_d;
    entry_t     in_entry;
    logic       push, pop;

`ifdef IF_ID_SKID_EN
    entry_t     e1_q, e1_d;

    // Ready depends on registered occupancy only, so ID back-pressure never
    // reaches the IF stage combinationally.
    assign if_ready_o = (count_q != 2'd2);
`else
    // Single register: it can take a new entry when empty or when the
    // current one is leaving in the same cycle.
    assign if_ready_o = (count_q == 2'd0) | id_ready_i;
`endif

    assign in_entry = '{pc:          if_pc_i,
                        instr:       if_instr_i,
                        prdt_taken:  if_prdt_taken_i,
                        pc_misalign: if_pc_misalign_i,
                        bus_err:     if_bus_err_i};

    // Flush kills both sides of the handshake in the same cycle.
    assign push = if_valid_i & if_ready_o & ~flush_i;
    assign pop  = id_valid_o & id_ready_i & ~flush_i;

    // Next occupancy and entry contents. Entry 0 is always the oldest.
    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
`ifdef IF_ID_SKID_EN
        e1_d    = e1_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    e0_d    = in_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    e0_d = in_entry;
                end else if (push) begin
                    e1_d    = in_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    e0_d    = e1_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
`else
        case (count_q)
            2'd0: begin
                if (push) begin
                    e0_d    = in_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push) begin
                    e0_d = in_entry;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: count_d = 2'd0;
        endcase
`endif
        if (flush_i) begin
            count_d = 2'd0;
        end
    end

    // Occupancy is the only state that needs a reset; stale entry contents
    // are hidden because the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        e0_q <= e0_d;
`ifdef IF_ID_SKID_EN
        e1_q <= e1_d;
`endif
    end

    assign id_valid_o       = (count_q != 2'd0);
    assign count_o          = count_q;
    assign id_pc_o          = id_valid_o ? e0_q.pc          : '0;
    assign id_instr_o       = id_valid_o ? e0_q.instr       : NOP_INSTR;
    assign id_prdt_taken_o  = id_valid_o & e0_q.prdt_taken;
    assign id_pc_misalign_o = id_valid_o & e0_q.pc_misalign;
    assign id_bus_err_o     = id_valid_o & e0_q.bus_err;

endmodule

// File: tb/tb_if_id_buf.sv
// ---------------------------------------------------------------------------
// tb_if_id_buf
//
// Self-checking bench for if_id_buf. A queue of entries models the buffer:
// entries are appended on an accepted offer and removed from the front on a
// consumed head; flush and reset empty the queue. Outputs are compared each
// cycle against the queue head and size. Build with or without
// IF_ID_SKID_EN to match the design.
// ---------------------------------------------------------------------------
module tb_if_id_buf;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_pc_i;
    logic [31:0] if_instr_i;
    logic        if_prdt_taken_i;
    logic        if_pc_misalign_i;
    logic        if_bus_err_i;
    logic        flush_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_prdt_taken_o;
    logic        id_pc_misalign_o;
    logic        id_bus_err_o;
    logic [1:0]  count_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pt;
        logic        mis;
        logic        be;
    } entry_t;

    entry_t model_q[$];
    int     n_compared   = 0;
    int     n_mismatched = 0;
    bit     armed        = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    if_id_buf #(.PC_WIDTH(32), .INSTR_WIDTH(32), .NOP_INSTR(NOP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_valid_i       (if_valid_i),
        .if_ready_o       (if_ready_o),
        .if_pc_i          (if_pc_i),
        .if_instr_i       (if_instr_i),
        .if_prdt_taken_i  (if_prdt_taken_i),
        .if_pc_misalign_i (if_pc_misalign_i),
        .if_bus_err_i     (if_bus_err_i),
        .flush_i          (flush_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_pc_o          (id_pc_o),
        .id_instr_o       (id_instr_o),
        .id_prdt_taken_o  (id_prdt_taken_o),
        .id_pc_misalign_o (id_pc_misalign_o),
        .id_bus_err_o     (id_bus_err_o),
        .count_o          (count_o)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model across the rising edge.
    task automatic applyStimulus(input bit v, input logic [31:0] pc,
                                 input logic [31:0] instr, input bit pt,
                                 input bit mis, input bit be, input bit fl,
                                 input bit idr, input bit rn);
        bit     exp_ready;
        bit     do_push;
        bit     do_pop;
        int     size;
        entry_t head;
        entry_t inc;
        @(negedge clk);
        rst_n            = rn;
        if_valid_i       = v;
        if_pc_i          = pc;
        if_instr_i       = instr;
        if_prdt_taken_i  = pt;
        if_pc_misalign_i = mis;
        if_bus_err_i     = be;
        flush_i          = fl;
        id_ready_i       = idr;
        #1;
        size = model_q.size();
        if (DEPTH == 2) exp_ready = (size < 2);
        else            exp_ready = (size == 0) || idr;
        if (size != 0) head = model_q[0];
        else           head = '{pc: 32'h0, instr: NOP, pt: 1'b0, mis: 1'b0, be: 1'b0};
        if (armed) begin
            checkOutput("id_valid",   64'(id_valid_o),       64'(size != 0));
            checkOutput("count",      64'(count_o),          64'(size));
            checkOutput("if_ready",   64'(if_ready_o),       64'(exp_ready));
            checkOutput("id_pc",      64'(id_pc_o),          64'(head.pc));
            checkOutput("id_instr",   64'(id_instr_o),       64'(head.instr));
            checkOutput("id_prdt",    64'(id_prdt_taken_o),  64'(head.pt));
            checkOutput("id_misalgn", 64'(id_pc_misalign_o), 64'(head.mis));
            checkOutput("id_bus_err", 64'(id_bus_err_o),     64'(head.be));
        end
        inc     = '{pc: pc, instr: instr, pt: pt, mis: mis, be: be};
        do_push = v && exp_ready && !fl;
        do_pop  = (size != 0) && idr && !fl;
        @(posedge clk);
        if (!rn || fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(inc);
        end
        if (!rn) armed = 1;
    endtask

    // Directed scenarios followed by a randomized run.
    initial begin
        // Reset held for two cycles while IF is offering.
        applyStimulus(1, 32'h0, 32'h1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h0, 32'h1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);

        // Streaming with ID always ready.
        applyStimulus(1, 32'h1000, 32'hA0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 32'h1004, 32'hA1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 32'h1008, 32'hA2, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 32'h0,    32'h0,  0, 0, 0, 0, 1, 1);

        // Back-pressure: two pushes, third offer held off, then drain.
        applyStimulus(1, 32'h2000, 32'hB0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h2004, 32'hB1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h2008, 32'hB2, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h2008, 32'hB2, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h2008, 32'hB2, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 32'h2008, 32'hB2, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 1);

        // Flush while full with a simultaneous push and pop.
        applyStimulus(1, 32'h3000, 32'hC0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h3004, 32'hC1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h3008, 32'hC2, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 1);

        // Flag passthrough.
        applyStimulus(1, 32'h4000, 32'hdeadbeef, 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 32'h0,    32'h0,        0, 0, 0, 0, 0, 1);
        applyStimulus(0, 32'h0,    32'h0,        0, 0, 0, 0, 1, 1);
        applyStimulus(0, 32'h0,    32'h0,        0, 0, 0, 0, 1, 1);

        // Randomized traffic with occasional flush and mid-run reset.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 49) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
